harmonic_mixer: RTL and testbench
=================================

Name: harmonic_mixer

Overview:
- Upstream feeder of the sample output stage (DAC formatting/ring-mod/SPI).
- Accepts one stream of harmonic contributions per sample period, each a signed sine value and an unsigned level.
- Scales each contribution and accumulates it into two 32-bit sums: odd harmonics go to L, even harmonics to R.
- Publishes both sums with a one-cycle start pulse for the output stage.

Parameters:
- HARMONICS, 64: contributions per frame; the frame closes when this many are accepted.
- LEVEL_SHIFT, 16: arithmetic right shift applied to each sine*level product.
- ACC_MAX, 32'sh3FFFFFFF: positive saturation bound of each accumulator. The negative bound is -ACC_MAX.

Ports:
- i_Clock  in  1  system clock
- i_Reset  in  1  reset
- i_Sample_Tick  in  1  one-cycle pulse: start of a sample period
- i_Valid  in  1  contribution present on i_Sine/i_Level/i_Index
- o_Ready  out  1  block accepts a contribution this cycle
- i_Index  in  8  harmonic index; 0 is the fundamental
- i_Sine  in  16  signed sine value of this harmonic
- i_Level  in  16  unsigned amplitude
- o_Sample_L  out  32  signed sum of even-index contributions (fundamental, 3rd, 5th…)
- o_Sample_R  out  32  signed sum of odd-index contributions
- o_Start  out  1  one-cycle pulse: o_Sample_L/R updated
- o_Overrun  out  1  sticky: a tick arrived before the frame closed

Behaviour:
- Reset is synchronous and active-high on i_Reset; clock is i_Clock.
- Reset values: all outputs 0, accumulators 0, counter 0, pipeline valids 0, state IDLE. Reset mid-frame abandons the frame with no o_Start.
- Transfer rule: a contribution is accepted when i_Valid && o_Ready at a rising edge. Inputs are sampled only on a transfer.
- State IDLE:
  - o_Ready=0.
  - On i_Sample_Tick: clear both accumulators and the counter, then go to ACCUM.
- State ACCUM:
  - o_Ready=1 while count<HARMONICS.
  - Each transfer increments count.
  - When count reaches HARMONICS, o_Ready drops the same cycle the counter updates, and the state moves to DRAIN.
- Pipeline, fully pipelined at one transfer per cycle:
  - Stage 1 registers p = signed(i_Sine) * signed({1'b0,i_Level}) (33-bit), plus the index LSB and a valid bit.
  - Stage 2 computes c = p >>> LEVEL_SHIFT, sign-extends it to 33 bits, and adds it to ACC_L when the LSB is 0, or to ACC_R when the LSB is 1.
- Saturating add: form the sum at 34 bits. If sum > ACC_MAX, store ACC_MAX; if sum < -ACC_MAX, store -ACC_MAX. The stored value never wraps.
- State DRAIN:
  - Wait until both pipeline valids are 0.
  - Then go to PUBLISH.
- State PUBLISH (1 cycle):
  - o_Sample_L<=ACC_L, o_Sample_R<=ACC_R, o_Start<=1, then back to IDLE.
  - o_Start is 0 in every other cycle.
  - o_Sample_L/R hold their values until the next PUBLISH.
- Latency: o_Start is asserted exactly 3 cycles after the edge that accepts the final contribution (stage1, stage2, DRAIN→PUBLISH register).
- i_Sample_Tick while in ACCUM or DRAIN (early tick):
  - Set o_Overrun=1. It is sticky and cleared only by reset.
  - Flush the pipeline valids, clear the accumulators and counter, and stay in or return to ACCUM for the new frame.
  - No o_Start is issued for the abandoned frame.
- i_Sample_Tick in the PUBLISH cycle: the publish completes, then the next cycle is treated as an IDLE tick and the new frame starts. The tick is not lost.
- A transfer with i_Level=0 still counts toward HARMONICS.
- i_Valid while o_Ready=0 is ignored. Upstream must hold the data.
- The output stage ignores o_Start while its DAC is busy. The mixer never stalls on the consumer.

Decomposition:
- Shared package mixer_pkg holds:
  - state encoding localparams (IDLE, ACCUM, DRAIN, PUBLISH);
  - the default ACC_MAX;
  - LEVEL_SHIFT;
  - an index width constant of 8.
- One sub-module, sat_accumulator:
  - inputs: clock, reset, clear, add-enable, 33-bit addend;
  - output: 32-bit saturated sum;
  - instantiated twice (L, R).

Test Plan:
- Tick, then HARMONICS=4 (bench override) contributions: idx0 sine=16384 lvl=65535; idx1 sine=-16384 lvl=32768; idx2 sine=8192 lvl=65535; idx3 sine=0 lvl=65535. Required: o_Start 3 cycles after the last transfer, L=16383+8191=24574, R=-8192.
- Back-to-back: i_Valid held high for 64 contributions of sine=32767, lvl=65535, indices 0..63. Required: o_Ready stays high for 64 consecutive cycles, and L=R=32×32766=1048512.
- Saturation: ACC_MAX=100000, 64 contributions of sine=32767, lvl=65535. Required: L=R=100000. With sine=-32768, required: L=R=-100000.
- Early tick after 10 of 64 transfers. Required: o_Overrun=1, no o_Start, the counter restarts, and a full 64 transfers then produce o_Start with sums of only the new frame.
- Tick coinciding with PUBLISH. Required: o_Start fires for the old frame, and the next frame is accepted starting the following cycle.
- Reset asserted mid-ACCUM. Required: all outputs 0 the next cycle, state IDLE, o_Ready=0, and no o_Start until a new tick plus a full frame.

Source files
------------

// File: rtl/harmonic_mixer_pkg.sv
// mixer_pkg: shared constants for the harmonic mixer (FSM encoding, defaults, widths)
package mixer_pkg;
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ACCUM   = 2'd1;
    localparam logic [1:0] ST_DRAIN   = 2'd2;
    localparam logic [1:0] ST_PUBLISH = 2'd3;

    localparam logic signed [31:0] DEF_ACC_MAX     = 32'sh3FFFFFFF;
    localparam int                 DEF_LEVEL_SHIFT = 16;
    localparam int                 IDX_W           = 8;
endpackage

// File: rtl/harmonic_mixer_if.sv
// harmonic_mixer_if: contribution stream in, published sample pair out
interface harmonic_mixer_if;
    import mixer_pkg::*;
    logic                    i_Sample_Tick;
    logic                    i_Valid;
    logic                    o_Ready;
    logic [IDX_W-1:0]        i_Index;
    logic signed [15:0]      i_Sine;
    logic [15:0]             i_Level;
    logic signed [31:0]      o_Sample_L;
    logic signed [31:0]      o_Sample_R;
    logic                    o_Start;
    logic                    o_Overrun;

    modport master (
        output i_Sample_Tick, i_Valid, i_Index, i_Sine, i_Level,
        input  o_Ready, o_Sample_L, o_Sample_R, o_Start, o_Overrun
    );

    modport slave (
        input  i_Sample_Tick, i_Valid, i_Index, i_Sine, i_Level,
        output o_Ready, o_Sample_L, o_Sample_R, o_Start, o_Overrun
    );
endinterface

// File: rtl/harmonic_mixer_sat_accumulator.sv
// sat_accumulator: 32-bit accumulator clamped to +/-ACC_MAX, clear wins over add
module sat_accumulator #(
    parameter logic signed [31:0] ACC_MAX = mixer_pkg::DEF_ACC_MAX
) (
    input  logic               i_Clock,
    input  logic               i_Reset,
    input  logic               clear_i,
    input  logic               add_i,
    input  logic signed [32:0] addend_i,
    output logic signed [31:0] sum_o
);
    localparam logic signed [33:0] HI = 34'(ACC_MAX);
    localparam logic signed [33:0] LO = -HI;

    logic signed [31:0] sum_q, sum_d;
    logic signed [33:0] wide;

    assign wide = $signed({{2{sum_q[31]}}, sum_q}) + $signed({addend_i[32], addend_i});

    // Next value: clear, hold, or the 34-bit sum clamped into range
    always_comb begin
        sum_d = clear_i ? '0 :
                !add_i ? sum_q :
                (wide > HI) ? ACC_MAX :
                (wide < LO) ? -ACC_MAX :
                wide[31:0];
    end

    // Accumulator register
    always_ff @(posedge i_Clock) begin
        if (i_Reset) sum_q <= '0;
        else sum_q <= sum_d;
    end

    assign sum_o = sum_q;
endmodule

// File: rtl/harmonic_mixer.sv
// harmonic_mixer: scales per-harmonic contributions and sums even/odd indices into L/R per frame
module harmonic_mixer
    import mixer_pkg::*;
#(
    parameter int                 HARMONICS   = 64,
    parameter int                 LEVEL_SHIFT = DEF_LEVEL_SHIFT,
    parameter logic signed [31:0] ACC_MAX     = DEF_ACC_MAX
) (
    input  logic              i_Clock,
    input  logic              i_Reset,
    harmonic_mixer_if.slave   bus
);
    localparam int CW = $clog2(HARMONICS + 1);

    logic [1:0]         state_q, state_d;
    logic [CW-1:0]      count_q, count_d;
    logic               s1_v_q;
    logic signed [32:0] prod_q;
    logic               lsb_q;
    logic               pend_q;
    logic               overrun_q;
    logic               start_q;
    logic signed [31:0] sample_l_q, sample_r_q;
    logic signed [31:0] acc_l, acc_r;
    logic signed [32:0] addend;
    logic               ready, transfer, early, begin_frame, clear;

    assign ready       = (state_q == ST_ACCUM) && (count_q < CW'(HARMONICS));
    assign transfer    = bus.i_Valid && ready;
    assign early       = bus.i_Sample_Tick && (state_q == ST_ACCUM || state_q == ST_DRAIN);
    assign begin_frame = (state_q == ST_IDLE) && (bus.i_Sample_Tick || pend_q);
    assign clear       = begin_frame || early;
    assign addend      = prod_q >>> LEVEL_SHIFT;

    // Frame sequencing; an early tick restarts the frame from any busy state
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        if (early) begin
            state_d = ST_ACCUM;
            count_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: if (begin_frame) begin
                    state_d = ST_ACCUM;
                    count_d = '0;
                end
                ST_ACCUM: if (transfer) begin
                    count_d = count_q + 1'b1;
                    state_d = (count_q == CW'(HARMONICS - 1)) ? ST_DRAIN : ST_ACCUM;
                end
                ST_DRAIN: state_d = s1_v_q ? ST_DRAIN : ST_PUBLISH;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    // State and contribution counter registers
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state_q <= ST_IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // Stage 1: full-precision product; the accumulator write is stage 2, so one valid covers the pipe
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            s1_v_q <= 1'b0;
            prod_q <= '0;
            lsb_q  <= 1'b0;
        end else begin
            s1_v_q <= transfer && !early;
            if (transfer) begin
                prod_q <= 33'(bus.i_Sine) * 33'($signed({1'b0, bus.i_Level}));
                lsb_q  <= bus.i_Index[0];
            end
        end
    end

    sat_accumulator #(.ACC_MAX(ACC_MAX)) u_acc_l (
        .i_Clock  (i_Clock),
        .i_Reset  (i_Reset),
        .clear_i  (clear),
        .add_i    (s1_v_q && !lsb_q),
        .addend_i (addend),
        .sum_o    (acc_l)
    );

    sat_accumulator #(.ACC_MAX(ACC_MAX)) u_acc_r (
        .i_Clock  (i_Clock),
        .i_Reset  (i_Reset),
        .clear_i  (clear),
        .add_i    (s1_v_q && lsb_q),
        .addend_i (addend),
        .sum_o    (acc_r)
    );

    // Publish, sticky overrun, and a tick seen during PUBLISH carried into IDLE
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            start_q    <= 1'b0;
            sample_l_q <= '0;
            sample_r_q <= '0;
            overrun_q  <= 1'b0;
            pend_q     <= 1'b0;
        end else begin
            start_q   <= (state_q == ST_PUBLISH);
            overrun_q <= overrun_q || early;
            pend_q    <= (state_q == ST_PUBLISH) ? bus.i_Sample_Tick : (begin_frame ? 1'b0 : pend_q);
            if (state_q == ST_PUBLISH) begin
                sample_l_q <= acc_l;
                sample_r_q <= acc_r;
            end
        end
    end

    assign bus.o_Ready    = ready;
    assign bus.o_Sample_L = sample_l_q;
    assign bus.o_Sample_R = sample_r_q;
    assign bus.o_Start    = start_q;
    assign bus.o_Overrun  = overrun_q;
endmodule

// File: tb/tb_harmonic_mixer.sv
// tb_harmonic_mixer: randomized checks of three mixer configurations against a frame-sum model
module tb_harmonic_mixer;
    logic               clk;
    logic               rst;
    logic               tick;
    logic               valid;
    logic [7:0]         idx;
    logic signed [15:0] sine;
    logic [15:0]        lvl;
    int                 total;
    int                 bad;
    int                 starts;
    longint             eb_l, eb_r, ec_l, ec_r;

    harmonic_mixer_if ia();
    harmonic_mixer_if ib();
    harmonic_mixer_if ic();

    assign ia.i_Sample_Tick = tick;
    assign ia.i_Valid       = valid;
    assign ia.i_Index       = idx;
    assign ia.i_Sine        = sine;
    assign ia.i_Level       = lvl;
    assign ib.i_Sample_Tick = tick;
    assign ib.i_Valid       = valid;
    assign ib.i_Index       = idx;
    assign ib.i_Sine        = sine;
    assign ib.i_Level       = lvl;
    assign ic.i_Sample_Tick = tick;
    assign ic.i_Valid       = valid;
    assign ic.i_Index       = idx;
    assign ic.i_Sine        = sine;
    assign ic.i_Level       = lvl;

    harmonic_mixer #(.HARMONICS(4)) dut_a (.i_Clock(clk), .i_Reset(rst), .bus(ia));
    harmonic_mixer dut_b (.i_Clock(clk), .i_Reset(rst), .bus(ib));
    harmonic_mixer #(.ACC_MAX(32'sd100000)) dut_c (.i_Clock(clk), .i_Reset(rst), .bus(ic));

    always #5 clk = ~clk;

    function automatic longint contrib(input longint s, input longint l);
        longint p, r;
        p = s * l;
        r = p % 65536;
        if (r < 0) r += 65536;
        return (p - r) / 65536;
    endfunction

    function automatic longint sat(input longint v, input longint m);
        return (v > m) ? m : ((v < -m) ? -m : v);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1; valid = 0; tick = 0;
        step();
        step();
        rst = 0;
    endtask

    task automatic new_frame();
        tick = 1;
        step();
        tick = 0;
        eb_l = 0; eb_r = 0; ec_l = 0; ec_r = 0;
    endtask

    task automatic feed(input int n, input int gap, input int mode, output int cycles);
        int  sent;
        logic rdy;
        longint c;
        sent = 0;
        cycles = 0;
        while (sent < n && cycles < 4000) begin
            valid = ($urandom_range(99) >= gap);
            if (mode == 0) begin
                idx  = 8'($urandom_range(255));
                sine = 16'($urandom_range(65535));
                lvl  = 16'($urandom_range(65535));
            end else begin
                idx  = 8'(sent);
                sine = (mode == 1) ? 16'sh7FFF : 16'sh8000;
                lvl  = 16'hFFFF;
            end
            rdy = ib.o_Ready;
            step();
            cycles++;
            if (ib.o_Start) starts++;
            if (valid && rdy) begin
                c = contrib(longint'(sine), longint'(lvl));
                if (idx[0]) begin
                    eb_r = sat(eb_r + c, 64'sh3FFFFFFF);
                    ec_r = sat(ec_r + c, 100000);
                end else begin
                    eb_l = sat(eb_l + c, 64'sh3FFFFFFF);
                    ec_l = sat(ec_l + c, 100000);
                end
                sent++;
            end
        end
        valid = 0;
        if (sent < n) begin
            bad++; total++;
            $display("FAIL feed_timeout: accepted %0d of %0d", sent, n);
        end
    endtask

    task automatic wait_start(output int lat, output logic c_st);
        lat = -1;
        c_st = 0;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (ib.o_Start) begin
                lat = k;
                c_st = ic.o_Start;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1; valid = 0; tick = 0; idx = 0; sine = 0; lvl = 0;
        step();
        step();
        total++; if (ib.o_Sample_L !== 32'sd0) begin bad++; $display("FAIL reset_L: got %0d want 0", ib.o_Sample_L); end
        total++; if (ib.o_Sample_R !== 32'sd0) begin bad++; $display("FAIL reset_R: got %0d want 0", ib.o_Sample_R); end
        total++; if ({ib.o_Start, ib.o_Overrun, ib.o_Ready} !== 3'b000) begin bad++; $display("FAIL reset_flags: got %b want 000", {ib.o_Start, ib.o_Overrun, ib.o_Ready}); end
        rst = 0;
        step();
        total++; if (ib.o_Ready !== 1'b0) begin bad++; $display("FAIL idle_ready: got %b want 0", ib.o_Ready); end
    endtask

    task automatic test_small();
        int   ts[4];
        int   tl[4];
        int   lat;
        logic rdy;
        ts = '{16384, -16384, 8192, 0};
        tl = '{65535, 32768, 65535, 65535};
        new_frame();
        for (int k = 0; k < 4; k++) begin
            valid = 1; idx = 8'(k); sine = 16'(ts[k]); lvl = 16'(tl[k]);
            rdy = ia.o_Ready;
            step();
            total++; if (rdy !== 1'b1) begin bad++; $display("FAIL small_ready%0d: got %b want 1", k, rdy); end
        end
        valid = 0;
        total++; if (ia.o_Ready !== 1'b0) begin bad++; $display("FAIL small_ready_drop: got %b want 0", ia.o_Ready); end
        lat = -1;
        for (int k = 1; k <= 20; k++) begin
            step();
            if (ia.o_Start) begin lat = k; break; end
        end
        total++; if (lat != 3) begin bad++; $display("FAIL small_latency: got %0d want 3", lat); end
        total++; if (ia.o_Sample_L !== 32'sd24574) begin bad++; $display("FAIL small_L: got %0d want 24574", ia.o_Sample_L); end
        total++; if (ia.o_Sample_R !== -32'sd8192) begin bad++; $display("FAIL small_R: got %0d want -8192", ia.o_Sample_R); end
        step();
        total++; if (ia.o_Start !== 1'b0) begin bad++; $display("FAIL small_start_pulse: got %b want 0", ia.o_Start); end
    endtask

    task automatic test_back_to_back();
        int   cyc, lat;
        logic cs;
        do_reset();
        new_frame();
        feed(64, 0, 1, cyc);
        total++; if (cyc != 64) begin bad++; $display("FAIL b2b_cycles: got %0d want 64", cyc); end
        wait_start(lat, cs);
        total++; if (lat != 3) begin bad++; $display("FAIL b2b_latency: got %0d want 3", lat); end
        total++; if (ib.o_Sample_L !== 32'sd1048512 || ib.o_Sample_R !== 32'sd1048512) begin bad++; $display("FAIL b2b_sums: got %0d/%0d want 1048512", ib.o_Sample_L, ib.o_Sample_R); end
        total++; if (cs !== 1'b1 || ic.o_Sample_L !== 32'sd100000 || ic.o_Sample_R !== 32'sd100000) begin bad++; $display("FAIL sat_pos: got %0d/%0d want 100000", ic.o_Sample_L, ic.o_Sample_R); end
    endtask

    task automatic test_saturation_neg();
        int   cyc, lat;
        logic cs;
        new_frame();
        feed(64, 10, 2, cyc);
        wait_start(lat, cs);
        total++; if (ic.o_Sample_L !== -32'sd100000 || ic.o_Sample_R !== -32'sd100000) begin bad++; $display("FAIL sat_neg: got %0d/%0d want -100000", ic.o_Sample_L, ic.o_Sample_R); end
        total++; if (ib.o_Sample_L !== -32'sd1048576 || ib.o_Sample_R !== -32'sd1048576) begin bad++; $display("FAIL neg_sums: got %0d/%0d want -1048576", ib.o_Sample_L, ib.o_Sample_R); end
    endtask

    task automatic test_random();
        int   cyc, lat;
        logic cs;
        for (int f = 0; f < 4; f++) begin
            new_frame();
            feed(64, 30, 0, cyc);
            wait_start(lat, cs);
            total++; if (lat != 3) begin bad++; $display("FAIL rand%0d_latency: got %0d want 3", f, lat); end
            total++; if (ib.o_Sample_L !== 32'(eb_l) || ib.o_Sample_R !== 32'(eb_r)) begin bad++; $display("FAIL rand%0d_b: got %0d/%0d want %0d/%0d", f, ib.o_Sample_L, ib.o_Sample_R, eb_l, eb_r); end
            total++; if (cs !== 1'b1 || ic.o_Sample_L !== 32'(ec_l) || ic.o_Sample_R !== 32'(ec_r)) begin bad++; $display("FAIL rand%0d_c: got %0d/%0d want %0d/%0d", f, ic.o_Sample_L, ic.o_Sample_R, ec_l, ec_r); end
        end
    endtask

    task automatic test_early_tick();
        int   cyc, lat;
        logic cs;
        do_reset();
        total++; if (ib.o_Overrun !== 1'b0) begin bad++; $display("FAIL early_pre_overrun: got %b want 0", ib.o_Overrun); end
        starts = 0;
        new_frame();
        feed(10, 0, 0, cyc);
        new_frame();
        total++; if (ib.o_Overrun !== 1'b1 || ic.o_Overrun !== 1'b1) begin bad++; $display("FAIL early_overrun: got %b%b want 11", ib.o_Overrun, ic.o_Overrun); end
        total++; if (ib.o_Ready !== 1'b1) begin bad++; $display("FAIL early_ready: got %b want 1", ib.o_Ready); end
        feed(64, 20, 0, cyc);
        total++; if (starts != 0) begin bad++; $display("FAIL early_no_start: got %0d starts want 0", starts); end
        wait_start(lat, cs);
        total++; if (lat != 3) begin bad++; $display("FAIL early_latency: got %0d want 3", lat); end
        total++; if (ib.o_Sample_L !== 32'(eb_l) || ib.o_Sample_R !== 32'(eb_r)) begin bad++; $display("FAIL early_sums: got %0d/%0d want %0d/%0d", ib.o_Sample_L, ib.o_Sample_R, eb_l, eb_r); end
        total++; if (ib.o_Overrun !== 1'b1) begin bad++; $display("FAIL early_sticky: got %b want 1", ib.o_Overrun); end
    endtask

    task automatic test_publish_tick();
        int   cyc, lat;
        logic cs;
        do_reset();
        new_frame();
        feed(64, 0, 0, cyc);
        step();
        step();
        tick = 1;
        step();
        tick = 0;
        total++; if (ib.o_Start !== 1'b1) begin bad++; $display("FAIL pub_tick_start: got %b want 1", ib.o_Start); end
        total++; if (ib.o_Sample_L !== 32'(eb_l) || ib.o_Sample_R !== 32'(eb_r)) begin bad++; $display("FAIL pub_tick_sums: got %0d/%0d want %0d/%0d", ib.o_Sample_L, ib.o_Sample_R, eb_l, eb_r); end
        eb_l = 0; eb_r = 0; ec_l = 0; ec_r = 0;
        step();
        total++; if (ib.o_Ready !== 1'b1) begin bad++; $display("FAIL pub_tick_next_ready: got %b want 1", ib.o_Ready); end
        feed(64, 10, 0, cyc);
        wait_start(lat, cs);
        total++; if (lat != 3 || ib.o_Sample_L !== 32'(eb_l) || ib.o_Sample_R !== 32'(eb_r)) begin bad++; $display("FAIL pub_tick_next_frame: lat %0d sums %0d/%0d want 3 %0d/%0d", lat, ib.o_Sample_L, ib.o_Sample_R, eb_l, eb_r); end
        total++; if (ib.o_Overrun !== 1'b0) begin bad++; $display("FAIL pub_tick_overrun: got %b want 0", ib.o_Overrun); end
    endtask

    task automatic test_reset_mid_frame();
        int   cyc, lat, seen;
        logic cs;
        new_frame();
        feed(64, 0, 1, cyc);
        wait_start(lat, cs);
        new_frame();
        feed(20, 0, 0, cyc);
        rst = 1;
        step();
        total++; if (ib.o_Sample_L !== 32'sd0 || ib.o_Sample_R !== 32'sd0) begin bad++; $display("FAIL rstmid_sums: got %0d/%0d want 0/0", ib.o_Sample_L, ib.o_Sample_R); end
        total++; if ({ib.o_Start, ib.o_Ready, ib.o_Overrun} !== 3'b000) begin bad++; $display("FAIL rstmid_flags: got %b want 000", {ib.o_Start, ib.o_Ready, ib.o_Overrun}); end
        rst = 0;
        seen = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            if (ib.o_Start || ib.o_Ready) seen++;
        end
        total++; if (seen != 0) begin bad++; $display("FAIL rstmid_idle: got %0d active cycles want 0", seen); end
        new_frame();
        feed(64, 25, 0, cyc);
        wait_start(lat, cs);
        total++; if (lat != 3 || ib.o_Sample_L !== 32'(eb_l) || ib.o_Sample_R !== 32'(eb_r)) begin bad++; $display("FAIL rstmid_new_frame: lat %0d sums %0d/%0d want 3 %0d/%0d", lat, ib.o_Sample_L, ib.o_Sample_R, eb_l, eb_r); end
    endtask

    initial begin
        clk = 0;
        total = 0;
        bad = 0;
        starts = 0;
        test_reset();
        test_small();
        test_back_to_back();
        test_saturation_neg();
        test_random();
        test_early_tick();
        test_publish_tick();
        test_reset_mid_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
